// File: rtl/video_timing_gen_pkg.sv
// Shared video timing package: axis config record, standard mode presets and
// the frame-counter width helper.
package video_timing_gen_pkg;

  typedef struct packed {
    logic        pol;
    logic [11:0] active;
    logic [11:0] front;
    logic [11:0] sync;
    logic [11:0] whole;
  } axis_cfg_t;

  localparam axis_cfg_t SVGA_H = '{pol: 1'b0, active: 12'd800, front: 12'd40,
                                   sync: 12'd128, whole: 12'd1056};
  localparam axis_cfg_t SVGA_V = '{pol: 1'b0, active: 12'd600, front: 12'd1,
                                   sync: 12'd4, whole: 12'd628};
  localparam axis_cfg_t VGA_H  = '{pol: 1'b1, active: 12'd640, front: 12'd16,
                                   sync: 12'd96, whole: 12'd800};
  localparam axis_cfg_t VGA_V  = '{pol: 1'b1, active: 12'd480, front: 12'd10,
                                   sync: 12'd2, whole: 12'd525};

  // Frame counter width; a single-frame rate still needs one bit.
  function automatic int fcw_f(input int f);
    return (f > 1) ? $clog2(f) : 1;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Config/match inputs and decoded timing outputs of the raster generator.
interface video_timing_gen_if #(
  parameter int HCW = 12,
  parameter int VCW = 12,
  parameter int FCW = 6
);
  logic [HCW-1:0] h_match;
  logic [VCW-1:0] v_match;
  logic           cfg_h_pol;
  logic [HCW-1:0] cfg_h_sync, cfg_h_active, cfg_h_front, cfg_h_whole;
  logic           cfg_v_pol;
  logic [VCW-1:0] cfg_v_sync, cfg_v_active, cfg_v_front, cfg_v_whole;

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic [FCW-1:0] f_cnt;
  logic           cnt_match, active, blank, a_start, a_end, h_sync, v_sync;

  modport master (
    output h_match, v_match,
           cfg_h_pol, cfg_h_sync, cfg_h_active, cfg_h_front, cfg_h_whole,
           cfg_v_pol, cfg_v_sync, cfg_v_active, cfg_v_front, cfg_v_whole,
    input  h_cnt, v_cnt, f_cnt, cnt_match, active, blank, a_start, a_end,
           h_sync, v_sync
  );

  modport slave (
    input  h_match, v_match,
           cfg_h_pol, cfg_h_sync, cfg_h_active, cfg_h_front, cfg_h_whole,
           cfg_v_pol, cfg_v_sync, cfg_v_active, cfg_v_front, cfg_v_whole,
    output h_cnt, v_cnt, f_cnt, cnt_match, active, blank, a_start, a_end,
           h_sync, v_sync
  );
endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping counter plus active-window / sync-window decode.
// inc_i is the carry in (always 1 for H, H wrap for V); wrap_o is the carry out.
module video_timing_axis #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en_i,
  input  logic          en_i,
  input  logic          inc_i,
  input  logic [CW-1:0] active_i,
  input  logic [CW-1:0] front_i,
  input  logic [CW-1:0] sync_i,
  input  logic [CW-1:0] whole_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          act_o,
  output logic          sync_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] sync_start, sync_end;
  logic          at_end;

  // >= rather than == so a config shrunk below the current count still wraps.
  assign at_end     = cnt_q >= whole_i - CW'(1);
  assign sync_start = active_i + front_i;
  assign sync_end   = sync_start + sync_i;

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && at_end;
  assign act_o  = cnt_q < active_i;
  assign sync_o = (cnt_q >= sync_start) && (cnt_q < sync_end);
  // An empty active window has no last pixel.
  assign last_o = (active_i != '0) && (cnt_q == active_i - CW'(1));

  // Next count: clear while disabled, otherwise step/wrap on carry in.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)      cnt_d = '0;
    else if (inc_i) cnt_d = at_end ? '0 : cnt_q + CW'(1);
  end

  // Counter register, advancing only on enabled clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt_q <= '0;
    else if (clk_en_i) cnt_q <= cnt_d;
  end
endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: H/V axis counters, frame counter and
// zero-latency decode of active/blank, frame strobes, position match and syncs.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int HCW   = 12,
  parameter int VCW   = 12,
  parameter int F_CNT = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en_i,
  input  logic               en_i,
  video_timing_gen_if.slave  vif
);
  localparam int FCW = fcw_f(F_CNT);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap, v_wrap, h_act, v_act, h_sraw, v_sraw, h_last, v_last;
  logic [FCW-1:0] f_cnt_q, f_cnt_d;

  video_timing_axis #(.CW(HCW)) u_h (
    .clk(clk), .rst(rst), .clk_en_i(clk_en_i), .en_i(en_i), .inc_i(1'b1),
    .active_i(vif.cfg_h_active), .front_i(vif.cfg_h_front),
    .sync_i(vif.cfg_h_sync), .whole_i(vif.cfg_h_whole),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .act_o(h_act), .sync_o(h_sraw), .last_o(h_last)
  );

  video_timing_axis #(.CW(VCW)) u_v (
    .clk(clk), .rst(rst), .clk_en_i(clk_en_i), .en_i(en_i), .inc_i(h_wrap),
    .active_i(vif.cfg_v_active), .front_i(vif.cfg_v_front),
    .sync_i(vif.cfg_v_sync), .whole_i(vif.cfg_v_whole),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .act_o(v_act), .sync_o(v_sraw), .last_o(v_last)
  );

  // Frame counter next state: V carry out marks the end of a frame.
  always_comb begin
    f_cnt_d = f_cnt_q;
    if (!en_i)       f_cnt_d = '0;
    else if (v_wrap) f_cnt_d = (f_cnt_q == FCW'(F_CNT - 1)) ? '0 : f_cnt_q + FCW'(1);
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          f_cnt_q <= '0;
    else if (clk_en_i) f_cnt_q <= f_cnt_d;
  end

  // Decode is purely combinational so every output describes the current pixel.
  assign vif.h_cnt     = h_cnt;
  assign vif.v_cnt     = v_cnt;
  assign vif.f_cnt     = f_cnt_q;
  assign vif.active    = en_i && h_act && v_act;
  assign vif.blank     = !vif.active;
  assign vif.a_start   = en_i && (h_cnt == '0) && (v_cnt == '0);
  assign vif.a_end     = en_i && h_last && v_last;
  assign vif.cnt_match = en_i && (h_cnt == vif.h_match) && (v_cnt == vif.v_match);
  assign vif.h_sync    = (en_i && h_sraw) ^ vif.cfg_h_pol;
  assign vif.v_sync    = (en_i && v_sraw) ^ vif.cfg_v_pol;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed timing checks on the standard presets
// plus randomized small rasters compared every cycle against a position model
// derived from the number of enabled clock edges since the counters were cleared.
module tb_video_timing_gen;
  import video_timing_gen_pkg::*;

  localparam int F_CNT = 60;

  logic clk = 1'b0;
  logic rst, clk_en, en;
  int   n_chk = 0, n_fail = 0, n_pos = 0;
  bit   model_on = 1'b1;

  video_timing_gen_if #(.HCW(12), .VCW(12), .FCW(6)) vif ();

  video_timing_gen #(.HCW(12), .VCW(12), .F_CNT(F_CNT)) dut (
    .clk(clk), .rst(rst), .clk_en_i(clk_en), .en_i(en), .vif(vif.slave)
  );

  always #5 clk = ~clk;

  // Model state: enabled edges since the counters were last cleared.
  always @(posedge clk or negedge rst) begin
    if (!rst)        n_pos = 0;
    else if (clk_en) n_pos = en ? n_pos + 1 : 0;
  end

  // Expected {h, v, f, match, active, blank, a_start, a_end, h_sync, v_sync}.
  function automatic logic [36:0] model_out();
    int ha, hf, hs, hw, va, vf, vs, vw, h, v, f;
    logic act, hsr, vsr;
    ha = int'(vif.cfg_h_active); hf = int'(vif.cfg_h_front);
    hs = int'(vif.cfg_h_sync);   hw = int'(vif.cfg_h_whole);
    va = int'(vif.cfg_v_active); vf = int'(vif.cfg_v_front);
    vs = int'(vif.cfg_v_sync);   vw = int'(vif.cfg_v_whole);
    h = n_pos % hw;
    v = (n_pos / hw) % vw;
    f = (n_pos / (hw * vw)) % F_CNT;
    act = en && (h < ha) && (v < va);
    hsr = en && (h >= ha + hf) && (h < ha + hf + hs);
    vsr = en && (v >= va + vf) && (v < va + vf + vs);
    return {12'(h), 12'(v), 6'(f),
            en && (h == int'(vif.h_match)) && (v == int'(vif.v_match)),
            act, !act, en && (h == 0) && (v == 0),
            en && (ha > 0) && (va > 0) && (h == ha - 1) && (v == va - 1),
            hsr ^ vif.cfg_h_pol, vsr ^ vif.cfg_v_pol};
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [36:0] e, a;
    if (model_on) begin
      e = model_out();
      a = {vif.h_cnt, vif.v_cnt, vif.f_cnt, vif.cnt_match, vif.active, vif.blank,
           vif.a_start, vif.a_end, vif.h_sync, vif.v_sync};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got h=%0d v=%0d f=%0d m/act/blk/st/end/hs/vs=%b want h=%0d v=%0d f=%0d m/act/blk/st/end/hs/vs=%b",
                 $time, a[36:25], a[24:13], a[12:7], a[6:0],
                 e[36:25], e[24:13], e[12:7], e[6:0]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear the counters with en=0, then load a new config while they sit at 0.
  task automatic set_cfg(input axis_cfg_t hc, input axis_cfg_t vc);
    en = 1'b0; clk_en = 1'b1;
    step(1);
    vif.cfg_h_pol = hc.pol; vif.cfg_h_active = hc.active; vif.cfg_h_front = hc.front;
    vif.cfg_h_sync = hc.sync; vif.cfg_h_whole = hc.whole;
    vif.cfg_v_pol = vc.pol; vif.cfg_v_active = vc.active; vif.cfg_v_front = vc.front;
    vif.cfg_v_sync = vc.sync; vif.cfg_v_whole = vc.whole;
    step(1);
    en = 1'b1;
  endtask

  function automatic axis_cfg_t rand_axis();
    axis_cfg_t c;
    int a, f, s, b;
    a = $urandom_range(0, 8); f = $urandom_range(0, 3);
    s = $urandom_range(1, 4); b = $urandom_range(0, 3);
    if (a + f + s + b < 2) b = 2 - (a + f + s);
    c.pol = 1'($urandom_range(0, 1));
    c.active = 12'(a); c.front = 12'(f); c.sync = 12'(s); c.whole = 12'(a + f + s + b);
    return c;
  endfunction

  initial begin
    axis_cfg_t hc, vc;
    int n_m, n_s, n_e;
    rst = 1'b0; en = 1'b1; clk_en = 1'b1;
    vif.h_match = '0; vif.v_match = '0;
    vif.cfg_h_pol = SVGA_H.pol; vif.cfg_h_active = SVGA_H.active; vif.cfg_h_front = SVGA_H.front;
    vif.cfg_h_sync = SVGA_H.sync; vif.cfg_h_whole = SVGA_H.whole;
    vif.cfg_v_pol = SVGA_V.pol; vif.cfg_v_active = SVGA_V.active; vif.cfg_v_front = SVGA_V.front;
    vif.cfg_v_sync = SVGA_V.sync; vif.cfg_v_whole = SVGA_V.whole;
    step(2);
    rst = 1'b1;

    // SVGA horizontal timing, every edge enabled.
    step(799);  chk("svga_h799", int'(vif.h_cnt), 799); chk("svga_act799", int'(vif.active), 1);
    step(1);    chk("svga_act800", int'(vif.active), 0); chk("svga_blank800", int'(vif.blank), 1);
    step(39);   chk("svga_hs839", int'(vif.h_sync), 0);
    step(1);    chk("svga_hs840", int'(vif.h_sync), 1);
    step(127);  chk("svga_hs967", int'(vif.h_sync), 1);
    step(1);    chk("svga_hs968", int'(vif.h_sync), 0);
    step(87);   chk("svga_h1055", int'(vif.h_cnt), 1055); chk("svga_v_pre", int'(vif.v_cnt), 0);
    step(1);    chk("svga_hwrap", int'(vif.h_cnt), 0); chk("svga_vinc", int'(vif.v_cnt), 1);

    // Asynchronous reset mid-line clears immediately.
    step(100);
    #2 rst = 1'b0;
    #1;
    chk("rst_h", int'(vif.h_cnt), 0); chk("rst_v", int'(vif.v_cnt), 0);
    chk("rst_f", int'(vif.f_cnt), 0); chk("rst_active", int'(vif.active), 1);
    chk("rst_astart", int'(vif.a_start), 1);
    en = 1'b0;
    #1;
    chk("dis_active", int'(vif.active), 0); chk("dis_blank", int'(vif.blank), 1);
    chk("dis_hs", int'(vif.h_sync), 0); chk("dis_vs", int'(vif.v_sync), 0);
    step(1);
    rst = 1'b1;

    // VGA preset, negative h sync; small negative-polarity vertical axis.
    set_cfg(VGA_H, '{pol: 1'b1, active: 12'd3, front: 12'd1, sync: 12'd2, whole: 12'd7});
    step(655);  chk("vga_hs655", int'(vif.h_sync), 1);
    step(1);    chk("vga_hs656", int'(vif.h_sync), 0);
    step(95);   chk("vga_hs751", int'(vif.h_sync), 0);
    step(1);    chk("vga_hs752", int'(vif.h_sync), 1);
    step(1648); chk("vga_v3", int'(vif.v_cnt), 3); chk("vga_vs3", int'(vif.v_sync), 1);
    step(800);  chk("vga_vs4", int'(vif.v_sync), 0);
    step(800);  chk("vga_vs5", int'(vif.v_sync), 0);
    step(800);  chk("vga_vs6", int'(vif.v_sync), 1);

    // Frame counter: 12 enabled edges per frame, wraps after 59.
    set_cfg('{pol: 1'b0, active: 12'd2, front: 12'd1, sync: 12'd1, whole: 12'd4},
            '{pol: 1'b0, active: 12'd2, front: 12'd0, sync: 12'd1, whole: 12'd3});
    step(12);      chk("f_first", int'(vif.f_cnt), 1);
    step(12 * 58); chk("f_59", int'(vif.f_cnt), 59);
    step(11);      chk("f_59_last", int'(vif.f_cnt), 59);
    step(1);       chk("f_wrap", int'(vif.f_cnt), 0); chk("f_wrap_h", int'(vif.h_cnt), 0);

    // clk_en every third cycle; strobes once per frame of 32 enabled edges.
    set_cfg('{pol: 1'b0, active: 12'd4, front: 12'd1, sync: 12'd1, whole: 12'd8},
            '{pol: 1'b0, active: 12'd2, front: 12'd1, sync: 12'd1, whole: 12'd4});
    vif.h_match = 12'd5; vif.v_match = 12'd2;
    n_m = 0; n_s = 0; n_e = 0;
    for (int i = 0; i < 96; i++) begin
      clk_en = (i % 3 == 0);
      #1;
      if (clk_en) begin
        n_m += int'(vif.cnt_match); n_s += int'(vif.a_start); n_e += int'(vif.a_end);
      end
      step(1);
    end
    chk("ce_match_cnt", n_m, 1); chk("ce_start_cnt", n_s, 1); chk("ce_end_cnt", n_e, 1);
    chk("ce_f", int'(vif.f_cnt), 1);

    // Random rasters, random clk_en, occasional en drops.
    for (int p = 0; p < 8; p++) begin
      hc = rand_axis(); vc = rand_axis();
      set_cfg(hc, vc);
      vif.h_match = 12'($urandom_range(0, int'(hc.whole) - 1));
      vif.v_match = 12'($urandom_range(0, int'(vc.whole) - 1));
      for (int i = 0; i < 700; i++) begin
        clk_en = ($urandom_range(0, 99) < 70);
        en = ($urandom_range(0, 199) != 0);
        step(1);
      end
    end

    // Shrinking the line length below the current pixel forces a wrap.
    clk_en = 1'b1;
    set_cfg(VGA_H, VGA_V);
    step(700);
    model_on = 1'b0;
    vif.cfg_h_whole = 12'd600;
    #1;
    chk("shrink_hold", int'(vif.h_cnt), 700);
    step(1); chk("shrink_wrap_h", int'(vif.h_cnt), 0); chk("shrink_wrap_v", int'(vif.v_cnt), 1);
    step(1); chk("shrink_next", int'(vif.h_cnt), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
